// File: rtl/csp_leaf_endpoint_if.sv
// -----------------------------------------------------------------------------
// csp_leaf_endpoint_if
//
// Bundles the client-side valid/ready channels and the tree-side four-phase
// bundled-data channels of one CSP leaf endpoint.
//
//   slave  : the endpoint's view (consumes tx_*, ch_in_*, ch_out_ack, rx_ready)
//   master : the environment's view (local client plus router tree)
//
// Signals
//   tx_data/tx_valid/tx_ready        client -> endpoint packet channel
//   rx_data/rx_valid/rx_ready        endpoint -> client packet channel
//   ch_out_data/ch_out_req/ch_out_ack endpoint -> tree leaf inport (4-phase)
//   ch_in_data/ch_in_req/ch_in_ack    tree leaf outport -> endpoint (4-phase)
// -----------------------------------------------------------------------------
interface csp_leaf_endpoint_if #(
    parameter int WIDTH = 11
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;

    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    logic [WIDTH-1:0] ch_out_data;
    logic             ch_out_req;
    logic             ch_out_ack;

    logic [WIDTH-1:0] ch_in_data;
    logic             ch_in_req;
    logic             ch_in_ack;

    modport slave (
        input  tx_data, tx_valid, rx_ready, ch_out_ack, ch_in_data, ch_in_req,
        output tx_ready, rx_data, rx_valid, ch_out_data, ch_out_req, ch_in_ack
    );

    modport master (
        output tx_data, tx_valid, rx_ready, ch_out_ack, ch_in_data, ch_in_req,
        input  tx_ready, rx_data, rx_valid, ch_out_data, ch_out_req, ch_in_ack
    );
endinterface

// File: rtl/csp_leaf_endpoint.sv
// -----------------------------------------------------------------------------
// csp_leaf_endpoint
//
// Leaf-side endpoint for one leaf of the 8-leaf CSP router tree. Packets from
// the synchronous client are buffered in a TX FIFO and injected into the
// tree's leaf inport with a four-phase req/ack handshake; packets from the
// tree's leaf outport are accepted with a four-phase handshake, buffered in
// an RX FIFO and presented to the client first-word-fall-through.
//
// Packet format: [WIDTH-1:WIDTH-3] destination leaf, [7:0] payload.
//
// Ports
//   clk         single clock
//   reset       asynchronous, active-low reset
//   bus         csp_leaf_endpoint_if.slave (client and tree channels)
//   drop_count  saturating count of misaddressed packets dropped
//
// Parameters
//   WIDTH        packet width
//   DEPTH        entries per FIFO (power of two, >= 2)
//   LEAF_ID      this leaf's address, 0..7
//   SYNC_STAGES  flops per synchronizer on ch_out_ack and ch_in_req (>= 2)
//
// Configuration macro
//   CSP_ADDR_CHECK_EN  when defined, received packets whose destination field
//                      differs from LEAF_ID are acknowledged but not stored,
//                      and drop_count counts them. When undefined every packet
//                      is stored and drop_count is tied to zero.
// -----------------------------------------------------------------------------
module csp_leaf_endpoint #(
    parameter int WIDTH       = 11,
    parameter int DEPTH       = 4,
    parameter int LEAF_ID     = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    csp_leaf_endpoint_if.slave bus,
    output logic [7:0]         drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        T_IDLE,
        T_SETUP,
        T_WAIT_HI,
        T_WAIT_LO
    } tx_state_t;

    typedef enum logic {
        R_IDLE,
        R_WAIT_LO
    } rx_state_t;

    // Pointers carry one extra wrap bit: equal low bits with differing wrap
    // bits means the FIFO holds DEPTH entries.
    function automatic logic ptr_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
        return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    endfunction

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("csp_leaf_endpoint: DEPTH must be a power of two >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("csp_leaf_endpoint: SYNC_STAGES must be >= 2");
    end
    if (LEAF_ID < 0 || LEAF_ID > 7) begin : g_bad_leaf
        $error("csp_leaf_endpoint: LEAF_ID must be 0..7");
    end
    if (WIDTH < 4) begin : g_bad_width
        $error("csp_leaf_endpoint: WIDTH must hold a 3-bit address");
    end

    // -------------------------------------------------------------------------
    // Synchronizers for the asynchronous handshake inputs
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   ack_s;
    logic                   req_s;

    // NOTE: clocked state is always written with <= so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_sync <= '0;
            req_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ch_out_ack};
            req_sync <= {req_sync[SYNC_STAGES-2:0], bus.ch_in_req};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign req_s = req_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] tx_mem [DEPTH];
    logic [PW-1:0]    tx_wr_ptr;
    logic [PW-1:0]    tx_rd_ptr;
    logic [PW-1:0]    tx_wr_nxt;
    logic [PW-1:0]    tx_rd_nxt;
    logic             tx_empty;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_ready_q;

    assign tx_empty  = (tx_wr_ptr == tx_rd_ptr);
    // tx_ready_q is exactly !full, so a push can never land on a full FIFO.
    assign tx_push   = bus.tx_valid && tx_ready_q;
    assign tx_wr_nxt = tx_wr_ptr + PW'(tx_push);
    assign tx_rd_nxt = tx_rd_ptr + PW'(tx_pop);

    // NOTE: storage arrays have no reset; the pointers alone define which
    // entries are valid, so clearing the data would buy nothing.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr[AW-1:0]] <= bus.tx_data;
        end
    end

    // tx_ready is registered from the post-update pointers, so it is held low
    // during reset and reflects !full in the same cycle the FIFO changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr  <= '0;
            tx_rd_ptr  <= '0;
            tx_ready_q <= 1'b0;
        end else begin
            tx_wr_ptr  <= tx_wr_nxt;
            tx_rd_ptr  <= tx_rd_nxt;
            tx_ready_q <= !ptr_full(tx_wr_nxt, tx_rd_nxt);
        end
    end

    assign bus.tx_ready = tx_ready_q;

    // -------------------------------------------------------------------------
    // TX FSM: four-phase master on the tree leaf inport
    // -------------------------------------------------------------------------
    tx_state_t        tx_state;
    tx_state_t        tx_state_nxt;
    logic             tx_load;
    logic             tx_req_set;
    logic             tx_req_clr;
    logic [WIDTH-1:0] ch_out_data_q;
    logic             ch_out_req_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= T_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_load      = 1'b0;
        tx_req_set   = 1'b0;
        tx_req_clr   = 1'b0;
        tx_pop       = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (!tx_empty) begin
                    tx_load      = 1'b1;
                    tx_state_nxt = T_SETUP;
                end
            end
            T_SETUP: begin
                // Data was loaded last cycle, so it leads req by one clock.
                tx_req_set   = 1'b1;
                tx_state_nxt = T_WAIT_HI;
            end
            T_WAIT_HI: begin
                if (ack_s) begin
                    tx_req_clr   = 1'b1;
                    tx_state_nxt = T_WAIT_LO;
                end
            end
            T_WAIT_LO: begin
                // The entry is retired only once the return-to-zero completes.
                if (!ack_s) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = T_IDLE;
                end
            end
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    // req and data are driven straight from flops so the asynchronous tree
    // never sees decode glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_out_data_q <= '0;
            ch_out_req_q  <= 1'b0;
        end else begin
            if (tx_load) begin
                ch_out_data_q <= tx_mem[tx_rd_ptr[AW-1:0]];
            end
            if (tx_req_set) begin
                ch_out_req_q <= 1'b1;
            end else if (tx_req_clr) begin
                ch_out_req_q <= 1'b0;
            end
        end
    end

    assign bus.ch_out_data = ch_out_data_q;
    assign bus.ch_out_req  = ch_out_req_q;

    // -------------------------------------------------------------------------
    // RX FIFO
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] rx_mem [DEPTH];
    logic [PW-1:0]    rx_wr_ptr;
    logic [PW-1:0]    rx_rd_ptr;
    logic             rx_empty;
    logic             rx_full;
    logic             rx_push;
    logic             rx_pop;

    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = ptr_full(rx_wr_ptr, rx_rd_ptr);
    assign rx_pop   = !rx_empty && bus.rx_ready;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr[AW-1:0]] <= bus.ch_in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            rx_wr_ptr <= rx_wr_ptr + PW'(rx_push);
            rx_rd_ptr <= rx_rd_ptr + PW'(rx_pop);
        end
    end

    // Empty slots read as zero so rx_data is defined straight out of reset.
    assign bus.rx_valid = !rx_empty;
    assign bus.rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr[AW-1:0]];

    // -------------------------------------------------------------------------
    // RX FSM: four-phase slave on the tree leaf outport
    // -------------------------------------------------------------------------
    rx_state_t rx_state;
    rx_state_t rx_state_nxt;
    logic      rx_accept;
    logic      rx_ack_clr;
    logic      addr_ok;
    logic      ch_in_ack_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= R_IDLE;
        end else begin
            rx_state <= rx_state_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_accept    = 1'b0;
        rx_ack_clr   = 1'b0;
        case (rx_state)
            R_IDLE: begin
                // A full FIFO holds ack low, which stalls the tree.
                if (req_s && !rx_full) begin
                    rx_accept    = 1'b1;
                    rx_state_nxt = R_WAIT_LO;
                end
            end
            R_WAIT_LO: begin
                if (!req_s) begin
                    rx_ack_clr   = 1'b1;
                    rx_state_nxt = R_IDLE;
                end
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // ch_in_data is sampled only here; bundled-data timing guarantees it has
    // settled by the time the synchronized req is seen.
    assign rx_push = rx_accept && addr_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_in_ack_q <= 1'b0;
        end else if (rx_accept) begin
            ch_in_ack_q <= 1'b1;
        end else if (rx_ack_clr) begin
            ch_in_ack_q <= 1'b0;
        end
    end

    assign bus.ch_in_ack = ch_in_ack_q;

    // -------------------------------------------------------------------------
    // Optional destination filter
    // -------------------------------------------------------------------------
`ifdef CSP_ADDR_CHECK_EN
    logic [7:0] drop_count_q;

    assign addr_ok = (bus.ch_in_data[WIDTH-1:WIDTH-3] == 3'(LEAF_ID));

    // Misaddressed packets are still acknowledged so the tree never stalls on
    // them; the counter sticks at its maximum rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count_q <= '0;
        end else if (rx_accept && !addr_ok && drop_count_q != 8'hFF) begin
            drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign addr_ok    = 1'b1;
    assign drop_count = '0;
`endif

endmodule

// File: doc/csp_leaf_endpoint.md
Name: csp_leaf_endpoint

Overview:
- Clocked leaf-side endpoint for one leaf of the 8-leaf CSP router tree (leaves A..H).
- Takes packets from a local synchronous client and injects them into the tree's leaf input channel.
- Receives packets from the tree's leaf output channel and hands them to the client.
- Both tree-side channels are four-phase bundled-data req/ack. The client side is valid/ready. Each direction is buffered by a small FIFO.

Parameters:
- WIDTH, 11: packet width; [10:8] = destination leaf (0=A..7=H), [7:0] = payload.
- DEPTH, 4: entries per FIFO (TX and RX); power of two, >=2.
- LEAF_ID, 0: this leaf's address, 0..7.
- SYNC_STAGES, 2: flops per synchronizer on incoming ch_out_ack and ch_in_req; >=2.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  WIDTH  client packet to send.
- tx_valid  in  1  client packet valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  WIDTH  received packet, head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  client accepts rx_data.
- ch_out_data  out  WIDTH  bundled data into tree leaf inport.
- ch_out_req  out  1  four-phase request to tree.
- ch_out_ack  in  1  four-phase ack from tree (asynchronous).
- ch_in_data  in  WIDTH  bundled data from tree leaf outport.
- ch_in_req  in  1  four-phase request from tree (asynchronous).
- ch_in_ack  out  1  four-phase ack to tree.
- drop_count  out  8  dropped misaddressed packets.

Behaviour:
- Reset (reset=0, async) clears everything:
  - tx_ready=0 while reset is asserted, 1 after release.
  - rx_valid=0; rx_data=0; ch_out_req=0; ch_out_data=0; ch_in_ack=0; drop_count=0.
  - FIFOs empty; both FSMs go to their idle state; synchronizer flops=0.
- Reset mid-handshake abandons the transfer. A packet in flight is lost; the tree side must be reset together with the endpoint.
- TX FIFO:
  - Push when tx_valid&&tx_ready. tx_ready = !full (registered).
  - A push and a pop in the same cycle are both legal when not empty. When full, only the pop happens that cycle.
- TX FSM, with ack_s = synchronized ch_out_ack:
  - T_IDLE: if FIFO not empty, load ch_out_data=head -> T_SETUP.
  - T_SETUP: ch_out_req=1 -> T_WAIT_HI. Data is stable at least one cycle before req rises.
  - T_WAIT_HI: when ack_s=1, ch_out_req=0 -> T_WAIT_LO.
  - T_WAIT_LO: when ack_s=0, pop FIFO -> T_IDLE.
  - ch_out_data is held from T_SETUP until the pop. Minimum cycle is 2+2*SYNC_STAGES+2 clocks per packet.
- RX FSM, with req_s = synchronized ch_in_req:
  - R_IDLE: if req_s=1 and RX FIFO not full, capture ch_in_data, push it, ch_in_ack=1 -> R_WAIT_LO.
  - If req_s=1 and the FIFO is full, stay in R_IDLE with ack low. This is backpressure into the tree.
  - R_WAIT_LO: when req_s=0, ch_in_ack=0 -> R_IDLE.
  - ch_in_data is sampled only in the capture cycle. Bundled-data timing guarantees it is stable once req_s is seen.
- RX FIFO:
  - Pop when rx_valid&&rx_ready.
  - Push from the RX FSM and pop by the client in the same cycle are both honored.
  - rx_data is the head entry, first-word-fall-through.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full/empty come from the MSB comparison.

Optional Feature:
- Macro: CSP_ADDR_CHECK_EN.
- Defined:
  - In R_IDLE, a captured packet with ch_in_data[10:8]!=LEAF_ID is acknowledged but not pushed.
  - drop_count increments and saturates at 255.
  - The FIFO-full check still gates acceptance.
- Undefined: every packet is pushed, and drop_count is tied to 0.

Test Plan:
- Reset release, idle channels -> tx_ready=1, rx_valid=0, ch_out_req=0, ch_in_ack=0, drop_count=0.
- Push tx_data=11'h5A3; tree responds ack 3 cycles after req, drops ack 3 cycles after req falls -> ch_out_data=11'h5A3 one cycle before req rises, single four-phase handshake, FIFO empty afterwards.
- Push 5 packets back-to-back with ch_out_ack held 0 -> tx_ready=0 after the 4th push; 5th is accepted only after the first handshake completes; packets leave in order.
- Tree sends 11'h0C1 (LEAF_ID=0) with rx_ready=0, then 4 more packets -> RX FIFO fills after 4; the 5th req stays unacked until rx_ready=1 pops one; order is preserved.
- With CSP_ADDR_CHECK_EN and LEAF_ID=2: receive 11'h2FF then 11'h5FF -> 11'h2FF delivered, 11'h5FF acked and dropped, drop_count=1.
- Assert reset during T_WAIT_HI -> ch_out_req falls immediately, FIFO empty; after release a fresh push completes normally.
